// File: rtl/ysyx_22040365_pkg.sv
// Shared types and constants for the ysyx_22040365 operand-fetch slice.
package ysyx_22040365_pkg;

   localparam int unsigned DefaultAddrWidth = 5;
   localparam int unsigned DefaultDataWidth = 64;
   localparam int unsigned ZeroReg          = 0;

   typedef enum logic [1:0] {
      StIdle,
      StRd1,
      StRd2,
      StHold
   } opfetch_state_e;

endpackage

// File: rtl/ysyx_22040365_opfetch_bypass.sv
// Selects write-back data over register-file data when the write-back hits the index
// being read this cycle; x0 never bypasses.
module ysyx_22040365_opfetch_bypass
   import ysyx_22040365_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
   parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
   input  logic                  wb_wen,
   input  logic [ADDR_WIDTH-1:0] wb_waddr,
   input  logic [DATA_WIDTH-1:0] wb_wdata,
   input  logic [ADDR_WIDTH-1:0] rf_raddr,
   input  logic [DATA_WIDTH-1:0] rf_rdata,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic hit;

   assign hit     = wb_wen && (wb_waddr == rf_raddr) && (rf_raddr != ADDR_WIDTH'(ZeroReg));
   assign rd_data = hit ? wb_wdata : rf_rdata;

endmodule

// File: rtl/ysyx_22040365_opfetch.sv
// Operand-fetch sequencer: reads rs1 then rs2 over one register-file port and holds both
// operands for execute. Define YSYX_22040365_WB_BYPASS_EN to forward same-cycle write-backs.
module ysyx_22040365_opfetch
   import ysyx_22040365_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
   parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_rs1,
   input  logic [ADDR_WIDTH-1:0] req_rs2,
   input  logic                  req_use_rs1,
   input  logic                  req_use_rs2,
   output logic                  rf_ren,
   output logic [ADDR_WIDTH-1:0] rf_raddr,
   input  logic [DATA_WIDTH-1:0] rf_rdata,
   input  logic                  wb_wen,
   input  logic [ADDR_WIDTH-1:0] wb_waddr,
   input  logic [DATA_WIDTH-1:0] wb_wdata,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [DATA_WIDTH-1:0] op_src1,
   output logic [DATA_WIDTH-1:0] op_src2
);

   opfetch_state_e        state_q;
   logic [ADDR_WIDTH-1:0] rs1_q;
   logic [ADDR_WIDTH-1:0] rs2_q;
   logic                  need2_q;
   logic [DATA_WIDTH-1:0] src1_q;
   logic [DATA_WIDTH-1:0] src2_q;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  need1_in;
   logic                  need2_in;

   assign need1_in = req_use_rs1 && (req_rs1 != ADDR_WIDTH'(ZeroReg));
   assign need2_in = req_use_rs2 && (req_rs2 != ADDR_WIDTH'(ZeroReg));

`ifdef YSYX_22040365_WB_BYPASS_EN
   ysyx_22040365_opfetch_bypass #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_bypass (
      .wb_wen  (wb_wen),
      .wb_waddr(wb_waddr),
      .wb_wdata(wb_wdata),
      .rf_raddr(rf_raddr),
      .rf_rdata(rf_rdata),
      .rd_data (rd_data)
   );
`else
   // Same-cycle write-back hazards are left to the hazard unit.
   logic unused_wb;
   assign unused_wb = ^{wb_wen, wb_waddr, wb_wdata};
   assign rd_data   = rf_rdata;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         rs1_q   <= '0;
         rs2_q   <= '0;
         need2_q <= 1'b0;
         src1_q  <= '0;
         src2_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  rs1_q   <= req_rs1;
                  rs2_q   <= req_rs2;
                  need2_q <= need2_in;
                  // Operands not fetched below must read as zero.
                  src1_q  <= '0;
                  src2_q  <= '0;
                  state_q <= need1_in ? StRd1 : (need2_in ? StRd2 : StHold);
               end
            end
            StRd1: begin
               src1_q  <= rd_data;
               state_q <= need2_q ? StRd2 : StHold;
            end
            StRd2: begin
               src2_q  <= rd_data;
               state_q <= StHold;
            end
            StHold: begin
               if (op_ready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      req_ready = 1'b0;
      op_valid  = 1'b0;
      rf_ren    = 1'b0;
      rf_raddr  = '0;
      if (!rst) begin
         unique case (state_q)
            StIdle: req_ready = 1'b1;
            StRd1: begin
               rf_ren   = 1'b1;
               rf_raddr = rs1_q;
            end
            StRd2: begin
               rf_ren   = 1'b1;
               rf_raddr = rs2_q;
            end
            StHold: op_valid = 1'b1;
            default: ;
         endcase
      end
   end

   assign op_src1 = src1_q;
   assign op_src2 = src2_q;

endmodule

// File: tb/tb_ysyx_22040365_opfetch.sv
// Bench for ysyx_22040365_opfetch: table vectors, reset corner cases and random requests
// against a transaction-level model of the register file and fetch timing.
module tb_ysyx_22040365_opfetch;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_rs1;
   logic [4:0]  req_rs2;
   logic        req_use_rs1;
   logic        req_use_rs2;
   logic        rf_ren;
   logic [4:0]  rf_raddr;
   logic [63:0] rf_rdata;
   logic        wb_wen;
   logic [4:0]  wb_waddr;
   logic [63:0] wb_wdata;
   logic        op_valid;
   logic        op_ready;
   logic [63:0] op_src1;
   logic [63:0] op_src2;

   logic [63:0] rf [32];
   int          vec_cnt;
   int          err_cnt;

   typedef struct {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      bit          u1;
      bit          u2;
      int          hold;
      int          wbm;
      logic [63:0] e1;
      logic [63:0] e2;
   } vec_t;

   vec_t tab[7];

   ysyx_22040365_opfetch #(
      .ADDR_WIDTH(5),
      .DATA_WIDTH(64)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_use_rs1(req_use_rs1),
      .req_use_rs2(req_use_rs2),
      .rf_ren     (rf_ren),
      .rf_raddr   (rf_raddr),
      .rf_rdata   (rf_rdata),
      .wb_wen     (wb_wen),
      .wb_waddr   (wb_waddr),
      .wb_wdata   (wb_wdata),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_src1    (op_src1),
      .op_src2    (op_src2)
   );

   assign rf_rdata = rf[rf_raddr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Register-file write lands at the edge; applied just after it so the DUT saw old data.
   task automatic step();
      @(posedge clk);
      #1;
      if (wb_wen && wb_waddr != 5'd0) rf[wb_waddr] = wb_wdata;
   endtask

   task automatic drive_wb(input int mode, input logic [4:0] idx);
      wb_wen   = 1'b0;
      wb_waddr = 5'd0;
      wb_wdata = 64'd0;
      if (mode == 1) begin
         wb_wen   = 1'($urandom_range(0, 1));
         wb_waddr = ($urandom_range(0, 1) == 1) ? idx : 5'($urandom_range(0, 7));
         wb_wdata = {$urandom(), $urandom()};
      end else if (mode == 2) begin
         wb_wen   = 1'b1;
         wb_waddr = idx;
         wb_wdata = 64'h77;
      end
   endtask

   task automatic run_txn(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1,
                          input bit u2, input int hold, input int wbm, input bit use_tab,
                          input logic [63:0] t1, input logic [63:0] t2);
      bit          n1, n2;
      int          nr;
      logic [4:0]  idx;
      logic [63:0] e1, e2, ev;
      n1 = u1 && (rs1 != 5'd0);
      n2 = u2 && (rs2 != 5'd0);
      nr = int'(n1) + int'(n2);
      e1 = 64'd0;
      e2 = 64'd0;
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid   = 1'b1;
      req_rs1     = rs1;
      req_rs2     = rs2;
      req_use_rs1 = u1;
      req_use_rs2 = u2;
      drive_wb((wbm == 1) ? 1 : 0, rs1);
      step();
      req_valid   = 1'b0;
      req_rs1     = 5'($urandom());
      req_rs2     = 5'($urandom());
      req_use_rs1 = 1'($urandom());
      req_use_rs2 = 1'($urandom());
      for (int c = 0; c < nr; c++) begin
         idx = (c == 0 && n1) ? rs1 : rs2;
         drive_wb(wbm, idx);
         #1;
         chk("rf_ren_read", 64'(rf_ren), 64'd1);
         chk("rf_raddr_read", 64'(rf_raddr), 64'(idx));
         chk("op_valid_read", 64'(op_valid), 64'd0);
         ev = rf[idx];
`ifdef YSYX_22040365_WB_BYPASS_EN
         if (wb_wen && wb_waddr == idx) ev = wb_wdata;
`endif
         if (c == 0 && n1) e1 = ev;
         else e2 = ev;
         step();
      end
      if (use_tab) begin
         e1 = t1;
         e2 = t2;
      end
      for (int h = 0; h <= hold; h++) begin
         drive_wb((wbm == 1) ? 1 : 0, (h % 2 == 1) ? rs1 : rs2);
         op_ready = (h == hold);
         #1;
         chk("op_valid_hold", 64'(op_valid), 64'd1);
         chk("req_ready_hold", 64'(req_ready), 64'd0);
         chk("rf_ren_hold", 64'(rf_ren), 64'd0);
         chk("rf_raddr_hold", 64'(rf_raddr), 64'd0);
         chk("op_src1", op_src1, e1);
         chk("op_src2", op_src2, e2);
         step();
      end
      op_ready = 1'b0;
      wb_wen   = 1'b0;
      #1;
      chk("op_valid_after_consume", 64'(op_valid), 64'd0);
   endtask

   initial begin
      vec_cnt     = 0;
      err_cnt     = 0;
      rst         = 1'b1;
      req_valid   = 1'b0;
      req_rs1     = 5'd0;
      req_rs2     = 5'd0;
      req_use_rs1 = 1'b0;
      req_use_rs2 = 1'b0;
      op_ready    = 1'b0;
      wb_wen      = 1'b0;
      wb_waddr    = 5'd0;
      wb_wdata    = 64'd0;
      rf[0] = 64'd0;
      for (int i = 1; i < 32; i++) rf[i] = {$urandom(), $urandom()};
      rf[3] = 64'h1111;
      rf[7] = 64'h2222;
      rf[5] = 64'hABCD;
      rf[9] = 64'h5;

      tab[0] = '{rs1: 5'd3, rs2: 5'd7, u1: 1, u2: 1, hold: 0, wbm: 0, e1: 64'h1111, e2: 64'h2222};
      tab[1] = '{rs1: 5'd0, rs2: 5'd5, u1: 1, u2: 1, hold: 0, wbm: 0, e1: 64'h0, e2: 64'hABCD};
      tab[2] = '{rs1: 5'd3, rs2: 5'd7, u1: 0, u2: 0, hold: 0, wbm: 0, e1: 64'h0, e2: 64'h0};
      tab[3] = '{rs1: 5'd3, rs2: 5'd0, u1: 1, u2: 1, hold: 1, wbm: 0, e1: 64'h1111, e2: 64'h0};
      tab[4] = '{rs1: 5'd7, rs2: 5'd3, u1: 1, u2: 0, hold: 0, wbm: 0, e1: 64'h2222, e2: 64'h0};
      tab[5] = '{rs1: 5'd5, rs2: 5'd9, u1: 0, u2: 1, hold: 5, wbm: 0, e1: 64'h0, e2: 64'h5};
`ifdef YSYX_22040365_WB_BYPASS_EN
      tab[6] = '{rs1: 5'd0, rs2: 5'd9, u1: 0, u2: 1, hold: 0, wbm: 2, e1: 64'h0, e2: 64'h77};
`else
      tab[6] = '{rs1: 5'd0, rs2: 5'd9, u1: 0, u2: 1, hold: 0, wbm: 2, e1: 64'h0, e2: 64'h5};
`endif

      // Reset state
      step();
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_op_valid", 64'(op_valid), 64'd0);
      chk("rst_rf_ren", 64'(rf_ren), 64'd0);
      step();
      rst = 1'b0;
      #1;
      chk("post_rst_req_ready", 64'(req_ready), 64'd1);
      chk("post_rst_src1", op_src1, 64'd0);
      chk("post_rst_src2", op_src2, 64'd0);

      for (int v = 0; v < 7; v++)
         run_txn(tab[v].rs1, tab[v].rs2, tab[v].u1, tab[v].u2, tab[v].hold, tab[v].wbm,
                 1'b1, tab[v].e1, tab[v].e2);

      // Reset in RD2 after rs1 was captured: operand must clear.
      req_valid   = 1'b1;
      req_rs1     = 5'd3;
      req_rs2     = 5'd7;
      req_use_rs1 = 1'b1;
      req_use_rs2 = 1'b1;
      step();
      req_valid = 1'b0;
      chk("rd1_raddr", 64'(rf_raddr), 64'd3);
      step();
      chk("rd2_src1_captured", op_src1, 64'h1111);
      rst = 1'b1;
      #1;
      chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
      chk("rst_mid_rf_ren", 64'(rf_ren), 64'd0);
      chk("rst_mid_op_valid", 64'(op_valid), 64'd0);
      step();
      rst = 1'b0;
      #1;
      chk("rst_rd2_idle", 64'(req_ready), 64'd1);
      chk("rst_rd2_src1", op_src1, 64'd0);
      chk("rst_rd2_rf_ren", 64'(rf_ren), 64'd0);

      // Reset in RD1, then a fresh request completes normally.
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      rst       = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rst_rd1_idle", 64'(req_ready), 64'd1);
      chk("rst_rd1_op_valid", 64'(op_valid), 64'd0);
      chk("rst_rd1_rf_ren", 64'(rf_ren), 64'd0);
      chk("rst_rd1_src1", op_src1, 64'd0);
      chk("rst_rd1_src2", op_src2, 64'd0);
      run_txn(5'd3, 5'd7, 1'b1, 1'b1, 0, 0, 1'b1, 64'h1111, 64'h2222);

      for (int r = 0; r < 60; r++)
         run_txn(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1, 1'b0, 64'd0, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/ysyx_22040365_opfetch.md
# ysyx_22040365_opfetch

Operand-fetch sequencer that drives the single combinational read port of the core's integer register file. It accepts a decoded source-register request, performs up to two sequential reads (rs1, then rs2) over that port, and presents both operands to the execute stage under a valid/ready handshake. It sits between decode and execute and snoops the write-back port so that same-cycle writes are forwarded.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 64, register data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  decode presents a request
- req_ready  out  1  block can accept a request
- req_rs1  in  ADDR_WIDTH  source register 1 index
- req_rs2  in  ADDR_WIDTH  source register 2 index
- req_use_rs1  in  1  rs1 operand required
- req_use_rs2  in  1  rs2 operand required
- rf_ren  out  1  register-file read enable
- rf_raddr  out  ADDR_WIDTH  register-file read address
- rf_rdata  in  DATA_WIDTH  register-file read data, combinational from rf_raddr
- wb_wen  in  1  write-back write enable (same signal driving the register file)
- wb_waddr  in  ADDR_WIDTH  write-back address
- wb_wdata  in  DATA_WIDTH  write-back data
- op_valid  out  1  operands available
- op_ready  in  1  execute consumes operands
- op_src1  out  DATA_WIDTH  rs1 operand
- op_src2  out  DATA_WIDTH  rs2 operand

## Operation
- States: IDLE, RD1, RD2, HOLD.
- IDLE: req_ready=1. On req_valid: capture rs1/rs2 indices and use flags; next state RD1 if rs1 needed, else RD2 if rs2 needed, else HOLD. "Needed" = use flag set and index != 0; a non-needed operand is loaded with 0.
- RD1: rf_ren=1, rf_raddr=rs1; capture read value into op_src1; next RD2 if rs2 needed, else HOLD.
- RD2: rf_ren=1, rf_raddr=rs2; capture into op_src2; next HOLD.
- HOLD: op_valid=1, op_src1/op_src2 stable. On op_ready: next IDLE. No new request is accepted in HOLD.
- Outside RD1/RD2: rf_ren=0, rf_raddr=0.
- Operands are snapshots; a write-back to a captured index after its read cycle does not update op_src1/op_src2.
- A write to a needed index that lands before its read cycle is seen through the register file normally.
- Reset (rst high at an edge, any state, including mid-read): state→IDLE, op_src1=op_src2=0, captured indices/flags cleared. While rst is high, req_ready=0, op_valid=0, rf_ren=0.

## Timing
- Request accepted at edge N (req_valid & req_ready).
- Both reads needed: RD1 in cycle N..N+1, RD2 N+1..N+2, op_valid high from N+2 after edge.
- One read needed: op_valid after 2 edges; none needed: op_valid after 1 edge.
- Consumption edge (op_valid & op_ready) returns to IDLE; req_ready high the following cycle. Minimum request spacing: 2 cycles (none needed) to 4 cycles (both).
- op_valid, once high, stays high with stable data until consumed.

## Configuration
- YSYX_22040365_WB_BYPASS_EN defined: in RD1/RD2, if wb_wen=1 and wb_waddr == rf_raddr (nonzero), captured value is wb_wdata instead of rf_rdata.
- Undefined: captured value is always rf_rdata; a same-cycle write yields the pre-write value, and the hazard is the hazard unit's responsibility. wb_* ports remain present and are ignored.

## Structure
- Shared package ysyx_22040365_pkg: state enum (IDLE/RD1/RD2/HOLD), default ADDR_WIDTH/DATA_WIDTH constants, zero-register index constant.
- One sub-module: ysyx_22040365_opfetch_bypass, combinational select of rf_rdata vs wb_wdata, instantiated only under YSYX_22040365_WB_BYPASS_EN.

## Test plan
- rs1=3 (0x1111), rs2=7 (0x2222), both used, op_ready=1 -> rf_raddr 3 then 7, op_valid 2 edges after accept, src1=0x1111, src2=0x2222.
- rs1=0, rs2=5 (0xABCD), both used -> single read of 5, src1=0, src2=0xABCD, op_valid after 2 edges.
- use_rs1=use_rs2=0 -> no rf_ren, op_valid after 1 edge, both operands 0.
- Bypass: in RD2 for rs2=9 (rf holds 0x5), wb_wen=1 waddr=9 wdata=0x77 -> src2=0x77 with macro, 0x5 without.
- op_ready held 0 for 5 cycles in HOLD -> op_valid and operands stable, req_ready=0; op_ready=1 -> IDLE, req_ready=1 next cycle.
- rst asserted in RD1 -> next cycle IDLE, op_valid=0, operands 0, rf_ren=0; fresh request then completes normally.
